pwm_duty_ramp_ctrl: RTL and testbench



---
 rtl/pwm_pkg.sv | 18 +
 rtl/ramp_prescaler.sv | 27 ++
 rtl/pwm_duty_ramp_ctrl.sv | 120 ++++++++++++
 tb/tb_pwm_duty_ramp_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty ramp controller: FSM encoding,
// default duty width and the step-size helper.
package pwm_pkg;

  localparam int DUTY_W_DEF = 8;

  typedef logic [1:0] ramp_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  // A programmed step of zero would stall the ramp forever, so it moves by one.
  function automatic logic [3:0] eff_step(input logic [3:0] step);
    return (step == 4'd0) ? 4'd1 : step;
  endfunction

endpackage

// File: rtl/ramp_prescaler.sv
// Rate prescaler for the duty ramp: counts 0..i_div and pulses o_tick on the
// terminal count, then wraps. i_clear holds the count at zero.
module ramp_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_count;

  assign o_tick = (r_count == i_div);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear || o_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Slews the PWM duty toward the SPI target in programmable steps/rate.
// Optional build macro PWM_RAMP_ZERO_SNAP_EN: target 0 snaps duty to 0 at once.
module pwm_duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [DUTY_W-1:0] i_target_duty,
  input  logic [3:0]        i_step_size,
  input  logic [DIV_W-1:0]  i_ramp_div,
  output logic [DUTY_W-1:0] o_duty_out,
  output logic              o_busy,
  output logic              o_done
);

  ramp_state_t              r_state;
  ramp_state_t              w_state_nxt;
  logic [DUTY_W-1:0]        r_duty;
  logic [DUTY_W-1:0]        w_duty_nxt;
  logic                     r_done;
  logic                     w_done_nxt;
  logic                     w_clear;
  logic                     w_tick;
  logic [3:0]               w_step;
  logic [DUTY_W:0]          w_up_sum;
  logic signed [DUTY_W+1:0] w_dn_diff;
  logic [DUTY_W-1:0]        w_up_duty;
  logic [DUTY_W-1:0]        w_dn_duty;

  assign w_clear = (r_state == ST_IDLE) || !i_enable;

  ramp_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_clear),
    .i_div   (i_ramp_div),
    .o_tick  (w_tick)
  );

  // Widened arithmetic so a step can neither wrap past full scale nor below zero.
  assign w_step    = eff_step(i_step_size);
  assign w_up_sum  = {1'b0, r_duty} + {{(DUTY_W-3){1'b0}}, w_step};
  assign w_dn_diff = $signed({2'b00, r_duty}) - $signed({{(DUTY_W-2){1'b0}}, w_step});
  assign w_up_duty = (w_up_sum > {1'b0, i_target_duty}) ? i_target_duty
                                                         : w_up_sum[DUTY_W-1:0];
  assign w_dn_duty = (w_dn_diff < $signed({2'b00, i_target_duty})) ? i_target_duty
                                                                    : w_dn_diff[DUTY_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_done_nxt  = 1'b0;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
`ifdef PWM_RAMP_ZERO_SNAP_EN
    end else if (i_target_duty == '0) begin
      w_state_nxt = ST_IDLE;
      w_duty_nxt  = '0;
      w_done_nxt  = (r_duty != '0);
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_target_duty > r_duty)      w_state_nxt = ST_UP;
          else if (i_target_duty < r_duty) w_state_nxt = ST_DOWN;
        end
        ST_UP: begin
          if (i_target_duty == r_duty) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else if (i_target_duty < r_duty) begin
            w_state_nxt = ST_DOWN;
          end else if (w_tick) begin
            w_duty_nxt = w_up_duty;
            if (w_up_duty == i_target_duty) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        ST_DOWN: begin
          if (i_target_duty == r_duty) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else if (i_target_duty > r_duty) begin
            w_state_nxt = ST_UP;
          end else if (w_tick) begin
            w_duty_nxt = w_dn_duty;
            if (w_dn_duty == i_target_duty) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_duty_out = r_duty;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Scoreboard bench for pwm_duty_ramp_ctrl: an arithmetic ramp model queues the
// expected outputs per cycle, a monitor pops and compares them.
module tb_pwm_duty_ramp_ctrl;

`ifdef PWM_RAMP_ZERO_SNAP_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  tgt = '0;
  logic [3:0]  step = '0;
  logic [15:0] div = '0;
  logic [7:0]  duty_out;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  pwm_duty_ramp_ctrl #(.DUTY_W(8), .DIV_W(16)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (en),
    .i_target_duty (tgt),
    .i_step_size   (step),
    .i_ramp_div    (div),
    .o_duty_out    (duty_out),
    .o_busy        (busy),
    .o_done        (done)
  );

  typedef struct {
    int duty;
    bit busy;
    bit done;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;

  // Reference: current duty, ramp direction (+1/-1, 0 = none), cycles into the tick period.
  int m_duty = 0;
  int m_dir = 0;
  int m_phase = 0;

  function automatic bit model_step(bit e, int t, int s, int d);
    int se;
    int sg;
    bit dn;
    se = (s == 0) ? 1 : s;
    sg = (t > m_duty) ? 1 : ((t < m_duty) ? -1 : 0);
    dn = 1'b0;
    if (!e) begin
      m_dir = 0;
      m_phase = 0;
    end else if (SNAP && t == 0) begin
      dn = (m_duty != 0);
      m_duty = 0;
      m_dir = 0;
      m_phase = 0;
    end else if (m_dir == 0) begin
      m_dir = sg;
      m_phase = 0;
    end else if (sg == 0) begin
      m_dir = 0;
      dn = 1'b1;
    end else if (sg != m_dir) begin
      m_dir = sg;
      m_phase = (m_phase == d) ? 0 : m_phase + 1;
    end else if (m_phase == d) begin
      m_phase = 0;
      if (m_dir > 0) m_duty = (m_duty + se > t) ? t : m_duty + se;
      else           m_duty = (m_duty - se < t) ? t : m_duty - se;
      if (m_duty == t) begin
        m_dir = 0;
        dn = 1'b1;
      end
    end else begin
      m_phase = m_phase + 1;
    end
    return dn;
  endfunction

  task automatic drive(input bit e, input int t, input int s, input int d);
    exp_t x;
    @(negedge clk);
    rst_n = 1'b1;
    en    = e;
    tgt   = t[7:0];
    step  = s[3:0];
    div   = d[15:0];
    x.done = model_step(e, t, s, d);
    x.duty = m_duty;
    x.busy = (m_dir != 0);
    sb.push_back(x);
  endtask

  task automatic run(input bit e, input int t, input int s, input int d, input int n);
    repeat (n) drive(e, t, s, d);
  endtask

  task automatic run_until_idle(input int t, input int s, input int d, input int limit,
                                input string name);
    int k;
    k = 0;
    drive(1'b1, t, s, d);
    while (m_dir != 0 && k < limit) begin
      drive(1'b1, t, s, d);
      k++;
    end
    if (m_dir != 0) begin
      miscompares++;
      $display("FAIL %s ramp did not settle within %0d cycles (duty=%0d)", name, limit, m_duty);
    end
  endtask

  task automatic run_until_duty(input int t, input int s, input int d, input int v,
                                input int limit, input string name);
    int k;
    k = 0;
    while (m_duty != v && k < limit) begin
      drive(1'b1, t, s, d);
      k++;
    end
    if (m_duty != v) begin
      miscompares++;
      $display("FAIL %s duty %0d not reached within %0d cycles (duty=%0d)", name, v, limit, m_duty);
    end
  endtask

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic sync_monitor();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    exp_t x;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_duty", int'(duty_out), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_done", int'(done), 0);
    m_duty = 0;
    m_dir = 0;
    m_phase = 0;
    x.duty = 0;
    x.busy = 1'b0;
    x.done = 1'b0;
    sb.push_back(x);
    @(negedge clk);
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        vectors++;
        if (duty_out !== 8'(x.duty) || busy !== x.busy || done !== x.done) begin
          miscompares++;
          $display("FAIL sb_cycle t=%0t got duty=%0d busy=%0b done=%0b want duty=%0d busy=%0b done=%0b",
                   $time, duty_out, busy, done, x.duty, x.busy, x.done);
        end
      end
    end
  end

  initial begin : stimulus
    int d0;
    int rdiv;
    int rtgt;
    int rstep;
    int k;
    bit ren;

    #2 rst_n = 1'b0;
    #2;
    check("reset_duty", int'(duty_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    repeat (2) @(negedge clk);

    // Basic ramp 0 -> 40 in steps of 10, one step every 4 cycles.
    sync_monitor();
    d0 = done_seen;
    run(1'b1, 40, 10, 3, 22);
    sync_monitor();
    check("ramp40_final_duty", int'(duty_out), 40);
    check("ramp40_done_pulses", done_seen - d0, 1);

    // Saturating step 250 -> 255 with step 15.
    run_until_idle(250, 15, 0, 100, "to250");
    run_until_idle(255, 15, 0, 10, "sat255");
    sync_monitor();
    check("sat255_duty", int'(duty_out), 255);

    // Reverse mid-ramp at duty 100.
    run_until_idle(100, 5, 1, 200, "to100");
    drive(1'b1, 200, 10, 1);
    sync_monitor();
    d0 = done_seen;
    run_until_idle(50, 10, 1, 100, "reverse50");
    sync_monitor();
    check("reverse50_duty", int'(duty_out), 50);
    check("reverse50_done_pulses", done_seen - d0, 1);

    // Enable drop at duty 60, then resume.
    run_until_duty(200, 10, 2, 60, 50, "hold60");
    sync_monitor();
    d0 = done_seen;
    run(1'b0, 200, 10, 2, 5);
    sync_monitor();
    check("hold60_duty", int'(duty_out), 60);
    check("hold60_no_done", done_seen - d0, 0);
    run_until_idle(200, 10, 2, 100, "resume200");

    // Asynchronous reset mid-ramp at 120, then ramp back.
    run_until_duty(20, 10, 0, 120, 50, "down120");
    do_reset();
    run_until_idle(20, 10, 0, 50, "after_reset");

    // Target 0 from 200: snap or ramp depending on build.
    run_until_idle(200, 15, 0, 50, "to200");
    drive(1'b1, 0, 15, 1);
    sync_monitor();
    check("zero_first_cycle", int'(duty_out), SNAP ? 0 : 200);
    run_until_idle(0, 15, 1, 100, "to0");

    // Randomized segments; ramp_div changes only while the engine is disabled.
    rtgt = 0;
    rstep = 1;
    for (int seg = 0; seg < 60; seg++) begin
      rdiv = $urandom_range(0, 3);
      drive(1'b0, rtgt, rstep, rdiv);
      for (int c = 0; c < 30; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          rtgt = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255);
        end
        rstep = $urandom_range(0, 15);
        ren = ($urandom_range(0, 9) != 0);
        drive(ren, rtgt, rstep, rdiv);
      end
      if (seg == 30) do_reset();
    end

    k = 0;
    while (sb.size() > 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    #2;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL sb_drain %0d entries left", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
